// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU: instruction field positions,
// FSM state encoding and the jump-condition decode.
package hack_pkg;

  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;

  // Jump field bit positions: j1 (<0), j2 (=0), j3 (>0)
  localparam int J_LT = 2;
  localparam int J_EQ = 1;
  localparam int J_GT = 0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    MREAD  = 2'd1,
    EXEC   = 2'd2,
    MWRITE = 2'd3
  } state_t;

  function automatic logic jumpTaken(logic [2:0] jmp, logic zr, logic ng);
    return (jmp[J_LT] & ng) | (jmp[J_EQ] & zr) | (jmp[J_GT] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU (zx/nx/zy/ny/f/no), DATA_W-wide two's complement.
module hack_alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [DATA_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic [DATA_W-1:0] xz, xn, yz, yn, fo;

  always_comb begin
    xz  = zx ? '0 : x;
    xn  = nx ? ~xz : xz;
    yz  = zy ? '0 : y;
    yn  = ny ? ~yz : yz;
    fo  = f ? xn + yn : xn & yn;
    out = no ? ~fo : fo;
    zr  = (out == '0);
    ng  = out[DATA_W-1];
  end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH/MREAD/EXEC/MWRITE over req/ack memory handshakes,
// with a soft restart that rewinds the PC but keeps A/D and the flags.
module hack_cpu_mc
  import hack_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 15,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              z,
  output logic              n,
  output logic              retire
);

  localparam logic [ADDR_W-1:0] RstPc = ADDR_W'(RESET_PC);

  state_t            state, stateNxt;
  logic [DATA_W-1:0] regA, regD, ir, mReg, aluReg;
  logic [ADDR_W-1:0] pcReg, memAddr, pcInc;
  logic              zReg, nReg, jmpReg;
  logic              live, isC, take;
  logic [5:0]        comp;
  logic [DATA_W-1:0] aluY, aluOut;
  logic              aluZr, aluNg;

  assign live  = rst_n & ~reset;
  assign isC   = ir[DATA_W-1];
  assign comp  = ir[COMP_HI:COMP_LO];
  assign aluY  = ir[A_BIT] ? mReg : regA;
  assign pcInc = pcReg + ADDR_W'(1);
  assign take  = isC & jumpTaken(ir[2:0], aluZr, aluNg);

  hack_alu #(.DATA_W(DATA_W)) uAlu (
    .x(regD), .y(aluY),
    .zx(comp[5]), .nx(comp[4]), .zy(comp[3]), .ny(comp[2]), .f(comp[1]), .no(comp[0]),
    .out(aluOut), .zr(aluZr), .ng(aluNg)
  );

  // Requests and retire are masked while any reset is asserted so a
  // coincident ack can never complete a transaction.
  always_comb begin
    stateNxt = state;
    imem_req = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    case (state)
      FETCH: begin
        imem_req = live;
        if (imem_ack)
          stateNxt = (imem_rdata[DATA_W-1] & imem_rdata[A_BIT]) ? MREAD : EXEC;
      end
      MREAD: begin
        dmem_re = live;
        if (dmem_ack) stateNxt = EXEC;
      end
      EXEC: begin
        if (isC & ir[DEST_M]) stateNxt = MWRITE;
        else begin
          stateNxt = FETCH;
          retire   = live;
        end
      end
      MWRITE: begin
        dmem_we = live;
        if (dmem_ack) begin
          stateNxt = FETCH;
          retire   = live;
        end
      end
      default: stateNxt = FETCH;
    endcase
    if (!live) stateNxt = FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      regA    <= '0;
      regD    <= '0;
      ir      <= '0;
      mReg    <= '0;
      aluReg  <= '0;
      memAddr <= '0;
      pcReg   <= RstPc;
      zReg    <= 1'b0;
      nReg    <= 1'b0;
      jmpReg  <= 1'b0;
    end else begin
      state <= stateNxt;
      if (reset) pcReg <= RstPc;
      else begin
        case (state)
          FETCH: if (imem_ack) begin
            ir      <= imem_rdata;
            // A is stable until EXEC, so this is both M address and jump target
            memAddr <= regA[ADDR_W-1:0];
          end
          MREAD: if (dmem_ack) mReg <= dmem_rdata;
          EXEC: begin
            if (!isC) begin
              regA  <= {1'b0, ir[DATA_W-2:0]};
              pcReg <= pcInc;
            end else begin
              if (ir[DEST_A]) regA <= aluOut;
              if (ir[DEST_D]) regD <= aluOut;
              zReg   <= aluZr;
              nReg   <= aluNg;
              aluReg <= aluOut;
              jmpReg <= take;
              if (!ir[DEST_M]) pcReg <= take ? memAddr : pcInc;
            end
          end
          MWRITE: if (dmem_ack) pcReg <= jmpReg ? memAddr : pcInc;
          default: ;
        endcase
      end
    end
  end

  assign imem_addr  = pcReg;
  assign dmem_addr  = memAddr;
  assign dmem_wdata = aluReg;
  assign pc         = pcReg;
  assign z          = zReg;
  assign n          = nReg;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed and randomized checks of hack_cpu_mc against an ISA-level Hack model,
// with req/ack memories that insert configurable wait states.
module tb_hack_cpu_mc;
  localparam int DW = 16, AW = 15, MEMSZ = 1 << AW;

  logic clk = 1'b0, rst_n = 1'b0, reset = 1'b0;
  logic imem_req, imem_ack = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic dmem_re, dmem_we, dmem_ack = 1'b0;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata = '0;
  logic [AW-1:0] pc;
  logic z, n, retire;

  hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .z(z), .n(n), .retire(retire)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [MEMSZ];
  logic [DW-1:0] ram [MEMSZ];
  logic [DW-1:0] mram [MEMSZ];
  logic [5:0] compTab [0:17] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
    6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  int total = 0, bad = 0;
  int iMin = 0, iMax = 0, dMin = 0, dMax = 0;
  int iCnt = 0, iTgt = 0, dCnt = 0, dTgt = 0;
  int retCnt = 0, reCycles = 0;
  logic [AW-1:0] lastReAddr = '0;
  logic [AW+DW-1:0] wq[$], ew[$];

  logic [DW-1:0] mA, mD;
  int mPC;
  logic mZ, mN;

  // Memory responders: wait target drawn when a transaction starts
  always begin
    @(posedge clk); #2;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (imem_req) begin
      if (iCnt == 0) iTgt = $urandom_range(iMin, iMax);
      if (iCnt >= iTgt) begin imem_ack = 1'b1; imem_rdata = rom[imem_addr]; iCnt = 0; end
      else iCnt++;
    end else iCnt = 0;
    if (dmem_re || dmem_we) begin
      if (dCnt == 0) dTgt = $urandom_range(dMin, dMax);
      if (dCnt >= dTgt) begin dmem_ack = 1'b1; dmem_rdata = ram[dmem_addr]; dCnt = 0; end
      else dCnt++;
    end else dCnt = 0;
  end

  always @(posedge clk) begin
    if (retire) retCnt++;
    if (dmem_re) begin reCycles++; lastReAddr = dmem_addr; end
    if (dmem_we && dmem_ack) begin
      wq.push_back({dmem_addr, dmem_wdata});
      ram[dmem_addr] = dmem_wdata;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic clearRom();
    for (int i = 0; i < MEMSZ; i++) rom[i] = '0;
  endtask

  task automatic doReset();
    rst_n = 1'b0; reset = 1'b0;
    cyc(2);
    rst_n = 1'b1; retCnt = 0; reCycles = 0; wq.delete();
  endtask

  task automatic runUntil(input int nRet, input int budget, input string tag);
    int c = 0;
    while (retCnt < nRet && c < budget) begin @(negedge clk); c++; end
    chk({tag, "-retired"}, 32'(retCnt), 32'(nRet));
  endtask

  function automatic logic [DW-1:0] genIns();
    logic [2:0] j;
    if ($urandom_range(0, 99) < 35) return {1'b0, 15'($urandom_range(0, 63))};
    j = ($urandom_range(0, 99) < 75) ? 3'b000 : 3'($urandom_range(1, 7));
    return {3'b111, 1'($urandom_range(0, 1)), compTab[$urandom_range(0, 17)],
            3'($urandom_range(0, 7)), j};
  endfunction

  // ISA-level reference: mnemonic-table ALU and signed jump conditions
  task automatic modelRun(input int nIns);
    logic [DW-1:0] ins, y, r, oldA;
    logic signed [DW-1:0] s;
    logic jmp;
    for (int k = 0; k < nIns; k++) begin
      ins = rom[mPC];
      if (!ins[15]) begin
        mA = {1'b0, ins[14:0]};
        mPC = (mPC + 1) % MEMSZ;
      end else begin
        oldA = mA;
        y = ins[12] ? mram[oldA[14:0]] : oldA;
        case (ins[11:6])
          6'b101010: r = '0;
          6'b111111: r = 16'd1;
          6'b111010: r = 16'hFFFF;
          6'b001100: r = mD;
          6'b110000: r = y;
          6'b001101: r = ~mD;
          6'b110001: r = ~y;
          6'b001111: r = -mD;
          6'b110011: r = -y;
          6'b011111: r = mD + 16'd1;
          6'b110111: r = y + 16'd1;
          6'b001110: r = mD - 16'd1;
          6'b110010: r = y - 16'd1;
          6'b000010: r = mD + y;
          6'b010011: r = mD - y;
          6'b000111: r = y - mD;
          6'b000000: r = mD & y;
          6'b010101: r = mD | y;
          default:   r = 'x;
        endcase
        s = r;
        mZ = (s == 0);
        mN = (s < 0);
        case (ins[2:0])
          3'd1: jmp = (s > 0);
          3'd2: jmp = (s == 0);
          3'd3: jmp = (s >= 0);
          3'd4: jmp = (s < 0);
          3'd5: jmp = (s != 0);
          3'd6: jmp = (s <= 0);
          3'd7: jmp = 1'b1;
          default: jmp = 1'b0;
        endcase
        if (ins[3]) begin mram[oldA[14:0]] = r; ew.push_back({oldA[14:0], r}); end
        if (ins[5]) mA = r;
        if (ins[4]) mD = r;
        mPC = jmp ? int'(oldA[14:0]) : (mPC + 1) % MEMSZ;
      end
    end
  endtask

  initial begin
    int c, r0;
    // hard reset, then the zero-wait store program
    clearRom();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007;
    rom[3] = 16'hE090; rom[4] = 16'h0000; rom[5] = 16'hE308;
    rst_n = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("rst-pc", 32'(pc), 0);
    chk("rst-ireq", 32'(imem_req), 0);
    chk("rst-flags", 32'({z, n, retire, dmem_re, dmem_we}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; retCnt = 0; wq.delete();
    @(negedge clk);
    chk("post-ireq", 32'(imem_req), 1);
    chk("post-iaddr", 32'(imem_addr), 0);
    runUntil(6, 100, "t2");
    chk("t2-pc", 32'(pc), 6);
    chk("t2-nwrites", 32'(wq.size()), 1);
    if (wq.size() > 0) chk("t2-write", 32'(wq[0]), 32'({15'd0, 16'd12}));

    // D=0 then D;JEQ to old A, then store D to M[1]
    clearRom();
    rom[0] = 16'hEA90; rom[1] = 16'h000A; rom[2] = 16'hE302;
    rom[10] = 16'h0001; rom[11] = 16'hE308;
    doReset();
    runUntil(3, 100, "t3");
    chk("t3-pc", 32'(pc), 10);
    chk("t3-zn", 32'({z, n}), 32'(2'b10));
    runUntil(5, 100, "t3b");
    chk("t3-nwrites", 32'(wq.size()), 1);
    if (wq.size() > 0) chk("t3-d", 32'(wq[0]), 32'({15'd1, 16'd0}));

    // M-operand read with three wait cycles
    clearRom();
    rom[0] = 16'h0003; rom[1] = 16'hFC10; rom[2] = 16'h0004; rom[3] = 16'hE308;
    ram[3] = 16'h8001;
    dMin = 3; dMax = 3;
    doReset();
    runUntil(2, 100, "t4");
    chk("t4-re-cycles", 32'(reCycles), 4);
    chk("t4-re-addr", 32'(lastReAddr), 3);
    chk("t4-zn", 32'({z, n}), 32'(2'b01));
    runUntil(4, 100, "t4b");
    if (wq.size() > 0) chk("t4-d", 32'(wq[0]), 32'({15'd4, 16'h8001}));

    // soft restart during a stalled read keeps D
    dMin = 20; dMax = 20; ram[3] = 16'h1234;
    reset = 1'b1; cyc(1); reset = 1'b0;
    c = 0;
    while (!dmem_re && c < 50) begin @(negedge clk); c++; end
    chk("t5-in-mread", 32'(dmem_re), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    clearRom();
    rom[0] = 16'h0005; rom[1] = 16'hE308;
    r0 = retCnt; wq.delete();
    @(negedge clk);
    chk("t5-re-masked", 32'({dmem_re, imem_req, retire}), 0);
    @(posedge clk); #1;
    reset = 1'b0; dMin = 0; dMax = 0;
    @(negedge clk);
    chk("t5-fetch", 32'({imem_req, dmem_re}), 32'(2'b10));
    chk("t5-iaddr", 32'(imem_addr), 0);
    chk("t5-no-retire", 32'(retCnt), 32'(r0));
    runUntil(r0 + 2, 100, "t5");
    chk("t5-nwrites", 32'(wq.size()), 1);
    if (wq.size() > 0) chk("t5-d-kept", 32'(wq[0]), 32'({15'd5, 16'h8001}));

    // D overflow to 0x8000 and PC wrap at 0x7FFF
    clearRom();
    rom[0] = 16'h7FFF; rom[1] = 16'hEC10; rom[2] = 16'hEA87; rom[16'h7FFF] = 16'hE7D0;
    doReset();
    runUntil(3, 100, "t6");
    chk("t6-jmp", 32'(pc), 32'h7FFF);
    rom[0] = 16'h0006; rom[1] = 16'hE308;
    runUntil(4, 100, "t6b");
    chk("t6-wrap", 32'(pc), 0);
    chk("t6-zn", 32'({z, n}), 32'(2'b01));
    runUntil(6, 100, "t6c");
    if (wq.size() > 0) chk("t6-d", 32'(wq[0]), 32'({15'd6, 16'h8000}));

    // randomized programs with random wait states
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < MEMSZ; i++) begin
        rom[i] = genIns();
        ram[i] = 16'($urandom);
        mram[i] = ram[i];
      end
      iMin = 0; iMax = 2; dMin = 0; dMax = 2;
      mA = '0; mD = '0; mPC = 0; mZ = 1'b0; mN = 1'b0; ew.delete();
      modelRun(400);
      doReset();
      runUntil(400, 5000, "rnd");
      chk("rnd-pc", 32'(pc), 32'(mPC));
      chk("rnd-zn", 32'({z, n}), 32'({mZ, mN}));
      chk("rnd-nwrites", 32'(wq.size()), 32'(ew.size()));
      for (int i = 0; i < wq.size() && i < ew.size(); i++)
        chk("rnd-write", 32'(wq[i]), 32'(ew[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
